distribuidor_tx: RTL and testbench
==================================

DISTRIBUIDOR_TX -- requirements
Module: distribuidor_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 6, word width; bits [1:0] = class, bits [DATA_W-1:2] = payload length in header words.
REQ-002 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_data  input  DATA_W  word from the packet source.
REQ-005 SHALL have port in_valid  input  1  in_data holds a valid word.
REQ-006 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-007 SHALL have port almost_full  input  4  per-class transmit FIFO almost-full flags.
REQ-008 SHALL have port full  input  4  per-class transmit FIFO full flags.
REQ-009 SHALL have port push  output  4  one-hot push strobes to the transmit FIFOs P0..P3.
REQ-010 SHALL have port data_out  output  DATA_W  word written with push.
REQ-011 SHALL have port busy  output  1  high while a packet payload is pending.

Function
REQ-012 SHALL implement FSM states IDLE (expect header) and PAYLOAD (remaining count > 0).
REQ-013 Transfer SHALL occur only when in_valid and in_ready are both high in the same cycle.
REQ-014 Target class SHALL be in_data[1:0] in IDLE and the latched header class in PAYLOAD.
REQ-015 in_ready SHALL be combinational: high only when almost_full[target] and full[target] are both low.
REQ-016 Header transfer in IDLE SHALL latch class and length; length > 0 moves to PAYLOAD; length 0 stays in IDLE.
REQ-017 Each payload transfer SHALL decrement the remaining count; count 1 -> 0 returns to IDLE in the same edge.
REQ-018 Every transferred word (header and payload) SHALL appear on data_out with push = one-hot(target) exactly one cycle later; push SHALL be 0 in cycles without a prior transfer.
REQ-019 At most one push bit SHALL be high in any cycle; data_out SHALL hold its last value when push is 0.
REQ-020 in_valid low or in_ready low SHALL leave state, count and latched class unchanged.
REQ-021 almost_full on a non-target class SHALL NOT affect in_ready.
REQ-022 A new header SHALL be accepted in the cycle after the last payload word (back-to-back packets, no bubble).
REQ-023 busy SHALL equal (state == PAYLOAD).

Reset
REQ-024 reset SHALL force state IDLE, count 0, latched class 0, push 0, data_out 0, counters 0 at the next edge.
REQ-025 reset mid-packet SHALL discard the remaining payload; the word presented in the reset cycle SHALL NOT be pushed.
REQ-026 in_ready SHALL be low while reset is high.

Configuration
REQ-027 With macro DISTRIBUIDOR_TX_STATS_EN defined, SHALL add output pkt_count (4 x 8 bits, packed class 3..0) counting accepted headers per class, wrapping 255 -> 0.
REQ-028 Without DISTRIBUIDOR_TX_STATS_EN, pkt_count port and counters SHALL be absent; all other behaviour identical.

Structure
REQ-029 Shared package pcie_tx_pkg SHALL hold class width (2), class field position, FSM state encoding and number of classes (4).
REQ-030 One sub-module dec_clase (2-bit class to 4-bit one-hot) SHALL be instantiated for push generation.

Verification
REQ-031 Header 6'b0010_01 (class 1, len 2) then 2 payload words, all flags 0 -> push 0010 for 3 consecutive cycles, each one cycle after its transfer; FSM back to IDLE.
REQ-032 Header class 3, len 0 followed by header class 0, len 1 -> push 1000 then 0001, 0001; busy high only during the class 0 payload.
REQ-033 Class 2 packet len 3; almost_full[2] high for 4 cycles after the first payload -> in_ready 0, no push, count held at 2; resumes and completes after release.
REQ-034 almost_full = 4'b1011 during a class 2 packet -> in_ready stays 1 and all words push 0100.
REQ-035 reset asserted after payload 1 of a len 5 packet -> push 0 next cycle, state IDLE, next word decoded as header.
REQ-036 With DISTRIBUIDOR_TX_STATS_EN, 256 class 0 headers with len 0 -> pkt_count[7:0] wraps to 0; other class counters stay 0.

Source files
------------

// File: rtl/pcie_tx_pkg.sv
// Shared definitions for the transmit-side packet distributor: class field,
// number of traffic classes and the distributor FSM encoding.
package pcie_tx_pkg;

    localparam int CLASS_W     = 2;
    localparam int CLASS_LSB   = 0;
    localparam int NUM_CLASSES = 4;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PAYLOAD = 1'b1
    } state_t;

endpackage

// File: rtl/distribuidor_tx_dec_clase.sv
// Class decoder: turns a 2-bit traffic class into the one-hot FIFO select.
module dec_clase
    import pcie_tx_pkg::*;
(
    input  logic [CLASS_W-1:0]     clase,
    output logic [NUM_CLASSES-1:0] onehot
);

    // NOTE: default every always_comb output before the conditional write so no latch is inferred.
    always_comb begin
        onehot        = '0;
        onehot[clase] = 1'b1;
    end

endmodule

// File: rtl/distribuidor_tx.sv
// Routes header-prefixed packets to one of four per-class transmit FIFOs.
// Optional per-class header counters are enabled with DISTRIBUIDOR_TX_STATS_EN.
module distribuidor_tx
    import pcie_tx_pkg::*;
#(
    parameter int DATA_W = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_CLASSES-1:0] almost_full,
    input  logic [NUM_CLASSES-1:0] full,
    output logic [NUM_CLASSES-1:0] push,
    output logic [DATA_W-1:0]      data_out,
    output logic                   busy
`ifdef DISTRIBUIDOR_TX_STATS_EN
    ,
    output logic [NUM_CLASSES*8-1:0] pkt_count
`endif
);

    localparam int LEN_W = DATA_W - CLASS_W;

    state_t                   state_q;
    logic [LEN_W-1:0]         count_q;
    logic [CLASS_W-1:0]       class_q;
    logic [NUM_CLASSES-1:0]   push_q;
    logic [DATA_W-1:0]        data_out_q;

    logic [CLASS_W-1:0]       hdr_class;
    logic [LEN_W-1:0]         hdr_len;
    logic [CLASS_W-1:0]       target;
    logic [NUM_CLASSES-1:0]   target_onehot;
    logic                     xfer;

    assign hdr_class = in_data[CLASS_LSB +: CLASS_W];
    assign hdr_len   = in_data[DATA_W-1:CLASS_W];

    // In IDLE the word on the bus is a header, so it names its own class.
    assign target   = (state_q == ST_IDLE) ? hdr_class : class_q;
    assign in_ready = !reset && !almost_full[target] && !full[target];
    assign xfer     = in_valid && in_ready;

    dec_clase u_dec_clase (
        .clase  (target),
        .onehot (target_onehot)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            class_q    <= '0;
            push_q     <= '0;
            data_out_q <= '0;
        end else begin
            push_q <= '0;
            if (xfer) begin
                push_q     <= target_onehot;
                data_out_q <= in_data;
                case (state_q)
                    ST_IDLE: begin
                        class_q <= hdr_class;
                        if (hdr_len != '0) begin
                            count_q <= hdr_len;
                            state_q <= ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        count_q <= count_q - LEN_W'(1);
                        if (count_q == LEN_W'(1)) state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef DISTRIBUIDOR_TX_STATS_EN
    logic [NUM_CLASSES*8-1:0] pkt_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_count_q <= '0;
        end else if (xfer && state_q == ST_IDLE) begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                if (hdr_class == c[CLASS_W-1:0])
                    pkt_count_q[c*8 +: 8] <= pkt_count_q[c*8 +: 8] + 8'd1;
            end
        end
    end

    assign pkt_count = pkt_count_q;
`endif

    assign push     = push_q;
    assign data_out = data_out_q;
    assign busy     = (state_q == ST_PAYLOAD);

endmodule

// File: tb/tb_distribuidor_tx.sv
// Directed bench for distribuidor_tx; DISTRIBUIDOR_TX_STATS_EN adds the counter wrap test.
module tb_distribuidor_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] almost_full;
    logic [3:0] full;
    logic [3:0] push;
    logic [5:0] data_out;
    logic       busy;
`ifdef DISTRIBUIDOR_TX_STATS_EN
    logic [31:0] pkt_count;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    distribuidor_tx #(.DATA_W(6)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .almost_full (almost_full),
        .full        (full),
        .push        (push),
        .data_out    (data_out),
        .busy        (busy)
`ifdef DISTRIBUIDOR_TX_STATS_EN
        ,
        .pkt_count   (pkt_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic word_out(input string tag, input logic [3:0] exp_push, input logic [5:0] exp_data,
                            input logic exp_busy);
        check({tag, ".push"}, 32'(push), 32'(exp_push));
        check({tag, ".data"}, 32'(data_out), 32'(exp_data));
        check({tag, ".busy"}, 32'(busy), 32'(exp_busy));
    endtask

    initial begin
        reset       = 1'b1;
        in_data     = '0;
        in_valid    = 1'b0;
        almost_full = '0;
        full        = '0;
        step();
        step();
        check("rst.ready", 32'(in_ready), 32'd0);
        word_out("rst", 4'b0000, 6'd0, 1'b0);
        reset = 1'b0;

        // Class 1, length 2: three consecutive pushes to P1.
        in_valid = 1'b1;
        in_data  = 6'b0010_01;
        #1 check("p1.hdr.ready", 32'(in_ready), 32'd1);
        step(); word_out("p1.hdr", 4'b0010, 6'b0010_01, 1'b1);
        in_data = 6'b1111_00;
        #1 check("p1.pl1.ready", 32'(in_ready), 32'd1);
        step(); word_out("p1.pl1", 4'b0010, 6'b1111_00, 1'b1);
        in_data = 6'b0000_11;
        step(); word_out("p1.pl2", 4'b0010, 6'b0000_11, 1'b0);

        // Class 3 length 0, then back-to-back class 0 length 1.
        in_data = 6'b0000_11;
        step(); word_out("p2.hdr3", 4'b1000, 6'b0000_11, 1'b0);
        in_data = 6'b0001_00;
        step(); word_out("p2.hdr0", 4'b0001, 6'b0001_00, 1'b1);
        in_data = 6'b1010_10;
        step(); word_out("p2.pl", 4'b0001, 6'b1010_10, 1'b0);
        in_valid = 1'b0;
        step(); word_out("p2.idle", 4'b0000, 6'b1010_10, 1'b0);

        // Class 2 length 3 with a 4-cycle almost_full stall after payload 1.
        in_valid = 1'b1;
        in_data  = 6'b0011_10;
        step(); word_out("p3.hdr", 4'b0100, 6'b0011_10, 1'b1);
        in_data = 6'b0101_01;
        step(); word_out("p3.pl1", 4'b0100, 6'b0101_01, 1'b1);
        almost_full = 4'b0100;
        in_data     = 6'b1100_11;
        for (int i = 0; i < 4; i++) begin
            #1 check("p3.stall.ready", 32'(in_ready), 32'd0);
            step(); word_out("p3.stall", 4'b0000, 6'b0101_01, 1'b1);
        end
        almost_full = 4'b0000;
        step(); word_out("p3.pl2", 4'b0100, 6'b1100_11, 1'b1);
        in_data = 6'b0110_00;
        step(); word_out("p3.pl3", 4'b0100, 6'b0110_00, 1'b0);

        // Non-target almost_full is ignored; full on the target blocks.
        almost_full = 4'b1011;
        in_data     = 6'b0001_10;
        #1 check("p4.hdr.ready", 32'(in_ready), 32'd1);
        step(); word_out("p4.hdr", 4'b0100, 6'b0001_10, 1'b1);
        in_data = 6'b1111_11;
        #1 check("p4.pl.ready", 32'(in_ready), 32'd1);
        step(); word_out("p4.pl", 4'b0100, 6'b1111_11, 1'b0);
        almost_full = 4'b0000;
        full        = 4'b0100;
        in_data     = 6'b0000_10;
        #1 check("p4.full.ready", 32'(in_ready), 32'd0);
        step(); word_out("p4.full", 4'b0000, 6'b1111_11, 1'b0);
        full = 4'b0000;

        // Reset after payload 1 of a length-5 class 1 packet.
        in_data = 6'b0101_01;
        step(); word_out("p5.hdr", 4'b0010, 6'b0101_01, 1'b1);
        in_data = 6'b0000_00;
        step(); word_out("p5.pl1", 4'b0010, 6'b0000_00, 1'b1);
        reset   = 1'b1;
        in_data = 6'b1111_10;
        #1 check("p5.rst.ready", 32'(in_ready), 32'd0);
        step(); word_out("p5.rst", 4'b0000, 6'd0, 1'b0);
        reset = 1'b0;
        // Blocking class 1 proves the next word is decoded as a class 3 header.
        almost_full = 4'b0010;
        in_data     = 6'b0001_11;
        #1 check("p5.new.ready", 32'(in_ready), 32'd1);
        step(); word_out("p5.new", 4'b1000, 6'b0001_11, 1'b1);
        almost_full = 4'b0000;
        in_data     = 6'b0100_00;
        step(); word_out("p5.newpl", 4'b1000, 6'b0100_00, 1'b0);
        in_valid = 1'b0;
        step(); word_out("p5.idle", 4'b0000, 6'b0100_00, 1'b0);

`ifdef DISTRIBUIDOR_TX_STATS_EN
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("st.reset", pkt_count, 32'd0);
        in_valid = 1'b1;
        in_data  = 6'b0000_00;
        for (int i = 0; i < 255; i++) step();
        check("st.255", pkt_count, 32'h0000_00ff);
        step();
        check("st.wrap", pkt_count, 32'd0);
        in_valid = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
